// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared constants and types for the 8x8 register file.
//               Holds default widths, depth, bulk-clear FSM state encoding
//               and the register word / address typedefs.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;
    localparam int RF_DEPTH  = 1 << RF_ADDR_W;

    // Bulk-clear sequencer states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    typedef logic [RF_DATA_W-1:0] reg_word_t;
    typedef logic [RF_ADDR_W-1:0] reg_addr_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : rf_clear_seq
// Description : IDLE/CLEAR sequencer for the register-file bulk clear.
//               On clr_req in IDLE it walks a counter over every address,
//               issuing one zero-write per cycle, then returns to IDLE.
// Ports       : clk, rst_n (async active-low), clr_req (start request),
//               busy (sequence in progress), clr_we / clr_addr (clear
//               write strobe and address into the storage write port).
// Revision    : 1.0 - initial release
// ============================================================================
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    // Last address of the sweep; termination is an explicit compare so the
    // counter's natural wrap is never relied upon.
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule : rf_clear_seq
`default_nettype wire

// File: rtl/reg_file_8x8.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_8x8
// Description : 8 x 8-bit general-purpose register file with two
//               combinational read ports, one synchronous write port and a
//               sequenced bulk clear (busy while sweeping).
//               Optional macro REGFILE_WRITE_BYPASS_EN forwards wdata to a
//               read port whose address matches an IDLE write in the same
//               cycle.
// Ports       : clk, rst_n (async active-low)
//               clr_req -> start bulk clear, busy <- clear in progress
//               we, waddr, wdata -> write port (ignored while busy)
//               raddr_a -> rdata_a (ALU operand A)
//               raddr_b -> rdata_b (operand-B mux register input)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_8x8
    import rf_pkg::*;
#(
    parameter int DATA_W  = RF_DATA_W,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              waddr_is_r0;
    logic              wr_ok;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign waddr_is_r0 = (R0_ZERO != 0) && (waddr == '0);

    // The normal write port only owns storage in IDLE; during CLEAR the
    // sequencer takes it over and any user write is lost.
    assign wr_ok = we && !busy && !waddr_is_r0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_we) begin
            regs[clr_addr] <= '0;
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_stored(input logic [ADDR_W-1:0] addr);
        if ((R0_ZERO != 0) && (addr == '0)) begin
            return '0;
        end
        return regs[addr];
    endfunction

`ifdef REGFILE_WRITE_BYPASS_EN
    // Forwarding is qualified with rst_n so reads are still forced to zero
    // while reset is held, even with a write pending on the inputs.
    logic fwd_ok;
    assign fwd_ok = wr_ok && rst_n;

    always_comb begin
        rdata_a = read_stored(raddr_a);
        rdata_b = read_stored(raddr_b);
        if (fwd_ok && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (fwd_ok && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
    end
`else
    always_comb begin
        rdata_a = read_stored(raddr_a);
        rdata_b = read_stored(raddr_b);
    end
`endif

endmodule : reg_file_8x8
`default_nettype wire

// File: tb/tb_reg_file_8x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_8x8
// Description : Self-checking bench for reg_file_8x8. A register-array model
//               tracks expected contents and remaining clear cycles; a
//               falling-edge process compares both read ports and busy
//               against it, and directed checks pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_8x8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       clr_req = 1'b0;
    logic       busy;
    logic       we      = 1'b0;
    logic [2:0] waddr   = '0;
    logic [7:0] wdata   = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic [7:0] rdata_a;
    logic [7:0] rdata_b;

    bit   clk_run  = 1'b0;
    bit   check_en = 1'b0;
    int   tests    = 0;
    int   fails    = 0;

    reg_file_8x8 #(
        .DATA_W  (8),
        .ADDR_W  (3),
        .R0_ZERO (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_req (clr_req),
        .busy    (busy),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    always #5 if (clk_run) clk = ~clk;

    // ---------------- behavioural model ----------------
    bit [7:0] m [8];
    int       clr_left = 0;   // clear cycles still to run (0 = idle)

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m[i] = 8'h00;
            clr_left = 0;
        end else if (clr_left > 0) begin
            m[8 - clr_left] = 8'h00;
            clr_left        = clr_left - 1;
        end else begin
            if (we && waddr != 3'd0) m[waddr] = wdata;
            if (clr_req) clr_left = 8;
        end
    end

    function automatic logic [7:0] exp_read(input logic [2:0] addr);
        if (!rst_n || addr == 3'd0) return 8'h00;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (we && clr_left == 0 && waddr == addr) return wdata;
`endif
        return m[addr];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_rdata_a", {24'd0, rdata_a}, {24'd0, exp_read(raddr_a)});
            check("cyc_rdata_b", {24'd0, rdata_b}, {24'd0, exp_read(raddr_b)});
            check("cyc_busy", {31'd0, busy}, {31'd0, (clr_left > 0)});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            #1;
            check({name, "_a"}, {24'd0, rdata_a}, 32'd0);
            check({name, "_b"}, {24'd0, rdata_b}, 32'd0);
        end
    endtask

    int n;
    int guard;

    initial begin
        // 1. Reset with clock idle
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("rst_read");
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        clk_run  = 1'b1;
        check_en = 1'b1;
        tick();

        // 2. Write/read
        raddr_a = 3'd3; raddr_b = 3'd5;
        we = 1'b1; waddr = 3'd3; wdata = 8'd21;
        #1;
`ifdef REGFILE_WRITE_BYPASS_EN
        check("bypass_a_r3", {24'd0, rdata_a}, 32'd21);
`endif
        tick();
        we = 1'b0;
        check("wr_r3", {24'd0, rdata_a}, 32'd21);
        write_reg(3'd5, 8'd31);
        check("wr_r5", {24'd0, rdata_b}, 32'd31);
        check("wr_r3_kept", {24'd0, rdata_a}, 32'd21);

        // 3. Register 0 reads zero, ignores writes
        raddr_a = 3'd0; raddr_b = 3'd0;
        we = 1'b1; waddr = 3'd0; wdata = 8'h42;
        #1;
        check("r0_wcyc_a", {24'd0, rdata_a}, 32'd0);
        tick();
        we = 1'b0;
        check("r0_a", {24'd0, rdata_a}, 32'd0);
        check("r0_b", {24'd0, rdata_b}, 32'd0);

        // 4. Bulk clear with a dropped mid-clear write and ignored clr_req
        for (int i = 1; i < 8; i++) write_reg(3'(i), 8'(41 + i));
        raddr_a = 3'd7; raddr_b = 3'd1;
        #1;
        check("fill_r7", {24'd0, rdata_a}, 32'd48);
        check("fill_r1", {24'd0, rdata_b}, 32'd42);
        raddr_a = 3'd2;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        n = 0; guard = 0;
        while (busy && guard < 20) begin
            n++; guard++;
            if (n == 3) begin
                we = 1'b1; waddr = 3'd2; wdata = 8'd53; clr_req = 1'b1;
            end else begin
                we = 1'b0; clr_req = 1'b0;
            end
            tick();
        end
        we = 1'b0; clr_req = 1'b0;
        check("clr_busy_cycles", 32'(n), 32'd8);
        check("clr_r2_dropped", {24'd0, rdata_a}, 32'd0);
        check_all_zero("clr_read");

        // 5. Reset during clear
        for (int i = 1; i < 8; i++) write_reg(3'(i), 8'hFF);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();   // now in the 4th busy cycle
        check("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_all_zero("abort_read");
        rst_n = 1'b1;
        tick();
        raddr_b = 3'd6;
        write_reg(3'd6, 8'h11);
        check("post_abort_r6", {24'd0, rdata_b}, 32'h11);
        check("post_abort_busy", {31'd0, busy}, 32'd0);

        // 6. Simultaneous write and clear request
        raddr_a = 3'd7;
        we = 1'b1; waddr = 3'd7; wdata = 8'h5A; clr_req = 1'b1;
        tick();
        we = 1'b0; clr_req = 1'b0;
        check("simul_r7_written", {24'd0, rdata_a}, 32'h5A);
        check("simul_busy", {31'd0, busy}, 32'd1);
        guard = 0;
        while (busy && guard < 20) begin
            guard++;
            tick();
        end
        check("simul_busy_done", {31'd0, busy}, 32'd0);
        check("simul_r7_cleared", {24'd0, rdata_a}, 32'd0);
        check("simul_r6_cleared", {24'd0, rdata_b}, 32'd0);

        tick();
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_reg_file_8x8
`default_nettype wire

// File: doc/reg_file_8x8.md
Name: reg_file_8x8

Overview:
- General-purpose register file for the 8-bit RISC datapath.
- Two asynchronous read ports and one synchronous write port.
- Read port B feeds the ALU operand-B 2:1 mux (register vs immediate); read port A feeds ALU operand A directly.
- Includes a sequenced bulk-clear operation, used by the core on soft reset, with a busy indication.

Parameters:
DATA_W, 8, register width in bits
ADDR_W, 3, register address width; DEPTH = 2**ADDR_W = 8 registers
R0_ZERO, 1, when 1 register 0 always reads 0 and ignores writes

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
clr_req  input  1  start bulk clear; sampled high in IDLE
busy  output  1  high while bulk clear is in progress
we  input  1  write enable
waddr  input  ADDR_W  write address
wdata  input  DATA_W  write data
raddr_a  input  ADDR_W  read address, port A
raddr_b  input  ADDR_W  read address, port B
rdata_a  output  DATA_W  read data, port A (to ALU operand A)
rdata_b  output  DATA_W  read data, port B (to operand-B mux input)

Behaviour:
- Reset: clk and an asynchronous, active-low reset (rst_n); one clock domain only.
- rst_n low forces, immediately and without waiting for a clock edge:
  - all registers to 0
  - state to IDLE, clear counter to 0
  - busy = 0
  - rdata_a = rdata_b = 0
- Reads are combinational, with zero latency from raddr or storage:
  - rdata_x = reg[raddr_x]
  - With R0_ZERO = 1, raddr_x == 0 returns 0.
- Writes:
  - In IDLE with we = 1, reg[waddr] <= wdata on the rising clk edge.
  - The new value is visible on the reads in the next cycle.
  - With R0_ZERO = 1, writes to address 0 are dropped.
- State machine, states IDLE and CLEAR:
  - IDLE -> CLEAR when clr_req = 1. In that same edge, cnt <= 0 and busy goes high from the next cycle.
  - CLEAR: each edge writes reg[cnt] <= 0 and does cnt <= cnt + 1.
  - CLEAR -> IDLE on the edge where cnt == DEPTH-1. busy is therefore high for exactly DEPTH = 8 cycles.
- During CLEAR:
  - we is ignored and the write is lost; the write port takes no part.
  - clr_req is ignored; the sequence is not restarted.
  - Reads stay live and return the partially cleared contents.
- Simultaneous we and clr_req in IDLE: the write is performed in that edge, then CLEAR starts. The write is overwritten when cnt reaches waddr.
- cnt is ADDR_W bits wide and wraps naturally. Termination uses the explicit compare, not overflow.
- rst_n asserted mid-CLEAR aborts the sequence: all registers are 0, state is IDLE.
- Address inputs are always in range (full 2**ADDR_W decode); there are no illegal addresses.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN
- Defined:
  - If we = 1, state is IDLE, waddr == raddr_x, and the address is not (R0_ZERO and 0), then rdata_x = wdata in the same cycle (write-through forwarding).
  - This covers both ports independently.
  - No bypass during CLEAR.
- Undefined:
  - Reads return the stored value only; the written value appears the cycle after the write.

Decomposition:
- Package rf_pkg holds:
  - DATA_W and ADDR_W defaults
  - DEPTH
  - state encoding: IDLE = 1'b0, CLEAR = 1'b1
  - the typedefs for reg word and reg address
- One natural sub-module, rf_clear_seq: the IDLE/CLEAR FSM plus counter.
  - Outputs busy, clr_we and clr_addr.
  - The top muxes the storage write port between the normal write and the clear write.

Test Plan:
1. Reset then read: assert rst_n = 0 with clk idle; check rdata_a = rdata_b = 0 for all addresses and busy = 0.
2. Write/read: write reg3 = 21 and reg5 = 31. Read raddr_a = 3 and raddr_b = 5; expect 21 and 31 the cycle after each write. With the bypass macro defined, the value is already visible in the write cycle.
3. R0: write reg0 = 0x42; read address 0 on both ports; expect 0 (R0_ZERO = 1).
4. Bulk clear:
   - Fill regs 1..7 with 42..48, pulse clr_req for 1 cycle.
   - busy is high for exactly 8 cycles.
   - A write reg2 = 53 issued mid-clear is dropped.
   - All reads are 0 after busy falls.
5. Reset mid-clear: start clear with regs holding 0xFF, assert rst_n = 0 on the 4th busy cycle; expect busy = 0 immediately and all regs 0; a fresh write reg6 = 0x11 works normally.
6. Simultaneous we and clr_req: write reg7 = 0x5A in the clr_req cycle; after clear, reg7 reads 0.
